fp_norm_round_pipe: RTL
=======================

Name: fp_norm_round_pipe

Overview:
- Pipelined, parametrised successor to the adder tree's combinational normalize/round stage.
- Takes the tree's raw magnitude, exponent and sign, and produces a packed IEEE-754 result of configurable format (FP32/FP16/BF16).
- Supports four rounding modes, IEEE-correct overflow and subnormal handling, and optional flush-to-zero.
- Sits between the adder tree and the result writeback; valid/ready handshake on both sides, 3-stage pipeline with full back-pressure.

Parameters:
- EXP_W, 8, exponent field width; bias = 2^(EXP_W-1)-1.
- MAN_W, 23, stored fraction width.
- GUARD_W, 3, extra low-order bits below the LSB in mant_raw; minimum 2.
- IN_W, 32, mant_raw width; must be >= MAN_W+GUARD_W+1.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- mant_raw  in  IN_W  unsigned magnitude; bit MAN_W+GUARD_W has weight 2^(E-bias).
- exp_in  in  EXP_W  biased exponent of the sum.
- sign_in  in  1  sign of the sum.
- rnd_mode  in  2  0=RNE, 1=RTZ, 2=RUP (toward +inf), 3=RDN (toward -inf).
- ftz_en  in  1  flush subnormal results to signed zero.
- out_valid  out  1  result beat valid.
- out_ready  in  1  downstream accepts the result.
- fp_out  out  1+EXP_W+MAN_W  packed result {sign, exp, frac}.
- overflow  out  1  result overflowed.
- underflow  out  1  tiny and inexact, or flushed.
- inexact  out  1  rounding discarded nonzero bits.
- zero_out  out  1  result is zero.

Behaviour:
- Reset (async assert, sync-to-clk deassert not required here) clears all three stage valids. Outputs reset to 0: out_valid, fp_out, and all four flags. in_ready reads 1 once rst_n is high. Reset mid-operation discards in-flight beats silently.
- Handshake:
  - A beat transfers on in_valid&in_ready and on out_valid&out_ready.
  - Stage k loads when it is empty or stage k+1 loads/drains in the same cycle.
  - in_ready = stage-1 load condition, combinational from out_ready; no combinational path from in_valid to out_valid.
  - Latency 3 cycles with no stall; throughput 1 beat/cycle. Order is preserved; no drop or duplication. Stalled stage contents and rnd_mode/ftz_en are held.
- Stage 1 (capture, LZC):
  - Register the inputs. E = max(exp_in, 1), treating exp_in=0 as subnormal.
  - Leading-one position p of mant_raw. Unbiased-biased result exponent e = E + p - (MAN_W+GUARD_W).
  - mant_raw=0 → zero path.
- Stage 2 (align, round):
  - If e>=1: normalise so the leading one sits at bit MAN_W+GUARD_W. Right shift ORs lost bits into the sticky bit; left shift fills zeros.
  - If e<1: further right shift by 1-e with sticky (shift ≥ width → all bits sticky); exponent field 0.
  - Round bit G = MSB of the guard field; S = OR of the remaining guard bits plus sticky. inexact = G|S.
  - Round-up decision by mode:
    - RNE: G&(S|lsb).
    - RTZ: 0.
    - RUP: ~sign&(G|S).
    - RDN: sign&(G|S).
  - Mantissa carry-out increments the exponent and renormalises. A subnormal rounding into the MSB becomes exp field 1.
- Stage 3 (pack, flags):
  - Overflow when final exp ≥ 2^EXP_W-1: overflow=1, inexact=1. Result is ±inf for RNE, for RUP with sign 0, and for RDN with sign 1; otherwise ±max finite (exp all-ones-minus-1, frac all ones).
  - Subnormal or zero result from nonzero input: underflow = inexact.
  - If ftz_en and the rounded exp field is 0 with nonzero input: output {sign,0,0}, underflow=1, zero_out=1.
  - Exact zero input: {sign_in,0,0}, zero_out=1, other flags 0.
  - Flags are only meaningful with out_valid; they are held with the data during a stall.
- Simultaneous drain and load on a full pipeline sustains full throughput.

Test Plan (default FP32 parameters):
- mant_raw=0x0400_0000, exp_in=127, sign 0, RNE → 3 cycles later fp_out=0x3F80_0000, all flags 0.
- mant_raw=0x0400_0004, exp_in=127 (tie, even LSB):
  - RNE → 0x3F80_0000, inexact=1.
  - RUP → 0x3F80_0001.
  - RDN with sign 1 → 0xBF80_0001.
- mant_raw=0x07FF_FFFC, exp_in=127, RNE → mantissa carry → 0x4000_0000, inexact=1.
- mant_raw=0x0800_0000, exp_in=254:
  - RNE → 0x7F80_0000, overflow=1.
  - RTZ → 0x7F7F_FFFF, overflow=1.
- mant_raw=0x0000_0008, exp_in=1:
  - ftz_en=0 → 0x0000_0001, underflow=0, inexact=0.
  - ftz_en=1 → 0x0000_0000, zero_out=1, underflow=1.
- Back-pressure and reset:
  - Stream 6 beats back-to-back with out_ready=0 for 5 cycles → in_ready falls after 3 accepted.
  - On out_ready=1, all 6 emerge in order, one per cycle.
  - Assert rst_n=0 mid-stream → out_valid=0 immediately, no stale beats afterwards.

Source files
------------

// File: rtl/fp_norm_round_pipe.sv
// fp_norm_round_pipe: three-stage normalise / round / pack pipeline that turns
// the adder tree's raw magnitude, exponent and sign into a packed IEEE-754
// value, with four rounding modes, overflow saturation and optional
// flush-to-zero. Valid/ready on both sides with full back-pressure.
module fp_norm_round_pipe #(
  parameter int EXP_W   = 8,
  parameter int MAN_W   = 23,
  parameter int GUARD_W = 3,
  parameter int IN_W    = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [IN_W-1:0]          mant_raw,
  input  logic [EXP_W-1:0]         exp_in,
  input  logic                     sign_in,
  input  logic [1:0]               rnd_mode,
  input  logic                     ftz_en,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [EXP_W+MAN_W:0]     fp_out,
  output logic                     overflow,
  output logic                     underflow,
  output logic                     inexact,
  output logic                     zero_out
);

  localparam int NW   = MAN_W + GUARD_W + 1;      // normalised width, hidden bit on top
  localparam int PW   = $clog2(IN_W);             // leading-one position width
  localparam int SE_W = EXP_W + PW + 2;           // signed working exponent width
  localparam int FW   = 1 + EXP_W + MAN_W;
  localparam int EMAX = (1 << EXP_W) - 1;

  localparam logic [1:0] RNE = 2'd0;
  localparam logic [1:0] RTZ = 2'd1;
  localparam logic [1:0] RUP = 2'd2;
  localparam logic [1:0] RDN = 2'd3;

  // Position of the most significant set bit (0 when v is zero).
  function automatic logic [PW-1:0] lead_one_pos(input logic [IN_W-1:0] v);
    logic [PW-1:0] pos;
    pos = '0;
    for (int i = 0; i < IN_W; i++)
      if (v[i]) pos = PW'(i);
    return pos;
  endfunction

  // Round-up decision for the four directed / nearest modes.
  function automatic logic round_up(input logic [1:0] mode, input logic sign,
                                    input logic g, input logic s, input logic lsb);
    logic up;
    case (mode)
      RNE:     up = g & (s | lsb);
      RTZ:     up = 1'b0;
      RUP:     up = ~sign & (g | s);
      default: up = sign & (g | s);
    endcase
    return up;
  endfunction

  // Overflow result: infinity when the mode rounds away from zero on this
  // side, otherwise the largest finite magnitude.
  function automatic logic [FW-1:0] sat_pack(input logic sign, input logic [1:0] mode);
    logic to_inf;
    to_inf = (mode == RNE) || ((mode == RUP) && !sign) || ((mode == RDN) && sign);
    if (to_inf)
      return {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    else
      return {sign, {{(EXP_W-1){1'b1}}, 1'b0}, {MAN_W{1'b1}}};
  endfunction

  logic vld_p1, vld_p2, vld_p3;
  logic ld_p1, ld_p2, ld_p3;

  assign ld_p3     = !vld_p3 || out_ready;
  assign ld_p2     = !vld_p2 || ld_p3;
  assign ld_p1     = !vld_p1 || ld_p2;
  assign in_ready  = ld_p1;
  assign out_valid = vld_p3;

  // ---- stage 1: capture inputs, leading-one detect, result exponent ----
  logic [EXP_W-1:0]        ebase_c;
  logic [PW-1:0]           lzc_c;
  logic signed [SE_W-1:0]  e_c;

  assign ebase_c = (exp_in == '0) ? EXP_W'(1) : exp_in;
  assign lzc_c   = lead_one_pos(mant_raw);
  assign e_c     = $signed(SE_W'(ebase_c) + SE_W'(lzc_c) - SE_W'(MAN_W + GUARD_W));

  logic [IN_W-1:0]         mant_p1;
  logic [PW-1:0]           pos_p1;
  logic signed [SE_W-1:0]  e_p1;
  logic                    sign_p1, zero_p1, ftz_p1;
  logic [1:0]              rnd_p1;

  // Stage valid bits advance whenever the stage they feed is loading.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else begin
      if (ld_p1) vld_p1 <= in_valid;
      if (ld_p2) vld_p2 <= vld_p1;
    end
  end

  // Stage 1 data register; holds while stalled.
  always_ff @(posedge clk) begin
    if (ld_p1 && in_valid) begin
      mant_p1 <= mant_raw;
      pos_p1  <= lzc_c;
      e_p1    <= e_c;
      sign_p1 <= sign_in;
      zero_p1 <= (mant_raw == '0);
      rnd_p1  <= rnd_mode;
      ftz_p1  <= ftz_en;
    end
  end

  // ---- stage 2: align (normalise or denormalise) and round ----
  logic signed [SE_W-1:0]  rs_c;
  logic [SE_W-1:0]         sh_c;
  logic [NW-1:0]           norm_c;
  logic                    sticky_c;

  // Net right-shift amount; negative means shift left. Tiny results get the
  // extra 1-e right shift so the exponent field lands at zero.
  always_comb begin
    rs_c = $signed(SE_W'(pos_p1)) - $signed(SE_W'(MAN_W + GUARD_W));
    if (e_p1 < $signed(SE_W'(1)))
      rs_c = rs_c + ($signed(SE_W'(1)) - e_p1);
    sh_c     = rs_c[SE_W-1] ? -rs_c : rs_c;
    norm_c   = '0;
    sticky_c = 1'b0;
    if (rs_c[SE_W-1]) begin
      norm_c = NW'(mant_p1 << sh_c);
    end else if (sh_c >= SE_W'(IN_W)) begin
      sticky_c = |mant_p1;
    end else begin
      norm_c   = NW'(mant_p1 >> sh_c);
      sticky_c = |(mant_p1 & ((IN_W'(1) << sh_c) - IN_W'(1)));
    end
  end

  logic                    g_c, s_c, up_c;
  logic [MAN_W:0]          sig_c;
  logic [MAN_W+1:0]        sum_c;
  logic signed [SE_W-1:0]  ebase2_c, efin_c;
  logic [MAN_W-1:0]        frac_c;

  // Round at the LSB and fold any carry back into the exponent.
  always_comb begin
    g_c      = norm_c[GUARD_W-1];
    s_c      = (|norm_c[GUARD_W-2:0]) | sticky_c;
    sig_c    = norm_c[NW-1:GUARD_W];
    up_c     = round_up(rnd_p1, sign_p1, g_c, s_c, sig_c[0]);
    sum_c    = {1'b0, sig_c} + (MAN_W+2)'(up_c);
    ebase2_c = (e_p1 >= $signed(SE_W'(1))) ? e_p1 : '0;
    efin_c   = ebase2_c;
    frac_c   = sum_c[MAN_W-1:0];
    if (sum_c[MAN_W+1]) begin
      efin_c = ebase2_c + $signed(SE_W'(1));
      frac_c = sum_c[MAN_W:1];
    end else if ((ebase2_c == '0) && sum_c[MAN_W]) begin
      efin_c = $signed(SE_W'(1));
    end
  end

  logic signed [SE_W-1:0]  exp_p2;
  logic [MAN_W-1:0]        frac_p2;
  logic                    sign_p2, zero_p2, inx_p2, ftz_p2;
  logic [1:0]              rnd_p2;

  // Stage 2 data register; holds while stalled.
  always_ff @(posedge clk) begin
    if (ld_p2 && vld_p1) begin
      exp_p2  <= efin_c;
      frac_p2 <= frac_c;
      sign_p2 <= sign_p1;
      zero_p2 <= zero_p1;
      inx_p2  <= g_c | s_c;
      rnd_p2  <= rnd_p1;
      ftz_p2  <= ftz_p1;
    end
  end

  // ---- stage 3: pack, saturate, flush, flags ----
  logic [FW-1:0] fp_c;
  logic          ovf_c, unf_c, inx_c, zro_c;

  // Select the packed result and the exception flags for this beat.
  always_comb begin
    fp_c  = {sign_p2, exp_p2[EXP_W-1:0], frac_p2};
    ovf_c = 1'b0;
    unf_c = 1'b0;
    inx_c = inx_p2;
    zro_c = 1'b0;
    if (zero_p2) begin
      fp_c  = {sign_p2, {(FW-1){1'b0}}};
      zro_c = 1'b1;
      inx_c = 1'b0;
    end else if (exp_p2 >= $signed(SE_W'(EMAX))) begin
      fp_c  = sat_pack(sign_p2, rnd_p2);
      ovf_c = 1'b1;
      inx_c = 1'b1;
    end else if (exp_p2 == '0) begin
      if (ftz_p2) begin
        fp_c  = {sign_p2, {(FW-1){1'b0}}};
        unf_c = 1'b1;
        zro_c = 1'b1;
      end else begin
        unf_c = inx_p2;
        zro_c = (frac_p2 == '0);
      end
    end
  end

  // Output register: cleared on reset, held with its flags during a stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p3    <= 1'b0;
      fp_out    <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      inexact   <= 1'b0;
      zero_out  <= 1'b0;
    end else if (ld_p3) begin
      vld_p3 <= vld_p2;
      if (vld_p2) begin
        fp_out    <= fp_c;
        overflow  <= ovf_c;
        underflow <= unf_c;
        inexact   <= inx_c;
        zero_out  <= zro_c;
      end
    end
  end

endmodule
